// File: rtl/div_16.sv
// Restoring unsigned 16/16 divider producing one quotient bit per clock.
// A zero divisor bypasses the iteration and reports quotient 16'hFFFF and remainder = dividend.
module div_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        div_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] ZDIV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [15:0] dvd_reg;
  logic [15:0] dvs_reg;
  logic [15:0] rem_reg;

  logic [16:0] shifted;
  logic [16:0] trial;
  logic        q_bit;
  logic [15:0] rem_next;
  logic [15:0] dvd_next;

  // The shifted remainder needs 17 bits so that divisors above 16'h8000 still divide correctly.
  always_comb begin
    shifted  = {rem_reg, dvd_reg[15]};
    trial    = shifted - {1'b0, dvs_reg};
    q_bit    = ~trial[16];
    rem_next = q_bit ? trial[15:0] : shifted[15:0];
    dvd_next = {dvd_reg[14:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      dvd_reg   <= 16'h0000;
      dvs_reg   <= 16'h0000;
      rem_reg   <= 16'h0000;
      quotient  <= 16'h0000;
      remainder <= 16'h0000;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            if (divisor == 16'h0000) begin
              state <= ZDIV;
            end else begin
              state    <= RUN;
              dvs_reg  <= divisor;
              rem_reg  <= 16'h0000;
              cnt      <= 4'd0;
              div_zero <= 1'b0;
            end
          end
        end
        ZDIV: begin
          state     <= DONE;
          quotient  <= 16'hFFFF;
          remainder <= dvd_reg;
          div_zero  <= 1'b1;
        end
        RUN: begin
          rem_reg <= rem_next;
          dvd_reg <= dvd_next;
          cnt     <= cnt + 4'd1;
          // Results become visible only on the final iteration, so RUN values never leak out.
          if (cnt == 4'd15) begin
            state     <= DONE;
            quotient  <= dvd_next;
            remainder <= rem_next;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_div_16.sv
// Self-checking bench for div_16: arithmetic reference model checked every cycle,
// plus directed literal cases and a randomized operand sweep.
`timescale 1ns/1ps
module tb_div_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_zero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  div_16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Reference model: countdown to result publication, results from plain / and %.
  int          m_cnt = 0;
  bit          m_done = 1'b0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  bit          m_dz = 1'b0, p_dz = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_q <= '0; m_r <= '0; m_dz <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1; m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
      end
    end else if (start) begin
      if (divisor == 16'd0) begin
        m_cnt <= 1; p_q <= 16'hFFFF; p_r <= dividend; p_dz <= 1'b1;
      end else begin
        m_cnt <= 16; p_q <= dividend / divisor; p_r <= dividend % divisor; p_dz <= 1'b0;
        m_dz <= 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, done, div_zero, quotient, remainder} !==
          {((m_cnt != 0) || m_done), m_done, m_dz, m_q, m_r}) begin
        errors++;
        $display("FAIL cycle_model t=%0t got busy=%b done=%b dz=%b q=%h r=%h expected busy=%b done=%b dz=%b q=%h r=%h",
                 $time, busy, done, div_zero, quotient, remainder,
                 ((m_cnt != 0) || m_done), m_done, m_dz, m_q, m_r);
      end
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input bit edz, input bit show);
    int cyc;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, (b == 16'd0) ? 1 : 16);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, edz);
    if (b != 16'd0) begin
      check("identity", longint'(quotient) * longint'(b) + longint'(remainder), longint'(a));
      check("rem_lt_div", (remainder < b) ? 1 : 0, 1);
    end
    if (show)
      $display("op %0d / %0d -> q=%0d r=%0d dz=%0b latency=%0d", a, b, quotient, remainder, div_zero, cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [15:0] a, b;
    rst_n = 1'b0; start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dz", div_zero, 0);
    start = 1'b0;
    rst_n = 1'b1;

    // Directed literal cases.
    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 1'b1);
    run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 1'b1);
    run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1'b1);
    run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0, 1'b1);

    // Reset during RUN iteration 8.
    @(negedge clk);
    dividend = 16'd1234; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    $display("abort: reset mid-run, done pulses after abort=%0d", ndone);
    run_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 1'b1);

    // start held high with operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    dividend = 16'($urandom); divisor = 16'($urandom_range(1, 65535));
    ndone = 0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      dividend = 16'($urandom); divisor = 16'($urandom_range(1, 65535));
      if (done) begin
        ndone++;
        $display("stream done %0d: q=%0d r=%0d", ndone, quotient, remainder);
      end
    end
    start = 1'b0;
    check("stream_done_count", ndone, 5);
    repeat (20) @(negedge clk);

    // Randomized sweep, roughly 10% zero divisors.
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 16'd0;
        1, 2, 3: b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      if (b == 16'd0)
        run_op(a, b, 16'hFFFF, a, 1'b1, 1'b0);
      else
        run_op(a, b, a / b, a % b, 1'b0, 1'b0);
      if (i % 250 == 0)
        $display("random op %0d: %0d / %0d -> q=%0d r=%0d dz=%0b", i, a, b, quotient, remainder, div_zero);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
